ezusb_tx_arbiter: RTL and testbench

- Shares the FPGA -> EZ-USB stream (DI/DI_valid/DI_ready/DI_enable of the bidirectional USB interface) between NCH independent 16-bit requester streams.
- Grants one requester at a time in round-robin order. Each grant is framed as one burst: header word, data words, trailer word.
- Bursts are bounded by requester end-of-packet, MAX_BURST words, or an idle timeout, so one channel cannot starve the others.
- Clocked on ifclk. Sits between the application stream sources and the USB interface.

---
 rtl/ezusb_tx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ezusb_tx_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ezusb_tx_arbiter.sv
// ezusb_tx_arbiter: round-robin share of the FPGA->EZ-USB DI stream between
// NCH 16-bit requester streams, each grant framed as header/data/trailer.
// Ports: ifclk/reset; req_data/req_valid/req_last/req_ready per channel;
// DI/DI_valid/DI_ready/DI_enable to the USB interface; grant_ch, busy status.
module ezusb_tx_arbiter #(
  parameter int NCH       = 4,
  parameter int MAX_BURST = 256,
  parameter int IDLE_TO   = 16
) (
  input  logic              ifclk,
  input  logic              reset,
  input  logic [NCH*16-1:0] req_data,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH-1:0]    req_last,
  output logic [NCH-1:0]    req_ready,
  output logic [15:0]       DI,
  output logic              DI_valid,
  input  logic              DI_ready,
  output logic              DI_enable,
  output logic [2:0]        grant_ch,
  output logic              busy
);
  localparam int IW = (IDLE_TO < 2) ? 1 : $clog2(IDLE_TO + 1);
  localparam logic [IW-1:0] ITO = IW'(IDLE_TO);
  localparam logic [12:0] MAXB = 13'(MAX_BURST);
  localparam logic [2:0] LASTCH = 3'(NCH - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA, TRL} state_t;

  state_t        state_q, state_d;
  logic [15:0]   di_q, di_d;
  logic          di_valid_q, di_valid_d;
  logic          di_enable_q, di_enable_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    rr_q, rr_d;
  logic [11:0]   cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;

  logic          advance;
  logic          g_valid, g_last;
  logic [15:0]   g_data;
  logic          found;
  logic [2:0]    pick;
  logic [12:0]   cnt_inc;
  logic          room;
  logic          accept;

  assign advance = !di_valid_q || DI_ready;
  assign cnt_inc = {1'b0, cnt_q} + 13'd1;
  assign room    = {1'b0, cnt_q} < MAXB;

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_q == 3'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[16*i +: 16];
      end
    end
  end

  // search starts just after the last granted channel
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = rr_q;
    for (int k = 1; k <= NCH; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      for (int j = 0; j < NCH; j++) begin
        if (!found && idx == j && req_valid[j]) begin
          found = 1'b1;
          pick  = 3'(j);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    di_d        = di_q;
    di_valid_d  = di_valid_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    req_ready   = '0;
    accept      = 1'b0;
    di_enable_d = (state_q != IDLE) || (|req_valid);
    unique case (state_q)
      IDLE: begin
        if (advance) di_valid_d = 1'b0;
        if (found) begin
          grant_d = pick;
          cnt_d   = '0;
          idle_d  = '0;
          state_d = HDR;
        end
      end
      HDR: begin
        if (advance) begin
          di_d       = {4'hA, 1'b0, grant_q, 8'h00};
          di_valid_d = 1'b1;
          state_d    = DATA;
        end
      end
      DATA: begin
        for (int i = 0; i < NCH; i++) begin
          req_ready[i] = (grant_q == 3'(i)) && advance && room;
        end
        accept = g_valid && advance && room;
        if (!g_valid && idle_q != ITO) idle_d = idle_q + IW'(1);
        if (accept) begin
          di_d       = g_data;
          di_valid_d = 1'b1;
          cnt_d      = cnt_inc[11:0];
          idle_d     = '0;
          if (g_last || cnt_inc == MAXB) state_d = TRL;
        end else begin
          if (advance) di_valid_d = 1'b0;
          // close a stalled burst; cnt_q != 0 keeps every burst non-empty
          if (IDLE_TO != 0 && !g_valid && cnt_q != '0 && idle_d == ITO)
            state_d = TRL;
        end
      end
      TRL: begin
        if (advance) begin
          di_d       = {4'h5, cnt_q};
          di_valid_d = 1'b1;
          rr_d       = grant_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      di_q        <= '0;
      di_valid_q  <= 1'b0;
      di_enable_q <= 1'b0;
      grant_q     <= LASTCH;
      rr_q        <= LASTCH;
      cnt_q       <= '0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      di_q        <= di_d;
      di_valid_q  <= di_valid_d;
      di_enable_q <= di_enable_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
    end
  end

  assign DI        = di_q;
  assign DI_valid  = di_valid_q;
  assign DI_enable = di_enable_q;
  assign grant_ch  = grant_q;
  assign busy      = state_q != IDLE;

endmodule

// File: tb/tb_ezusb_tx_arbiter.sv
// Bench for ezusb_tx_arbiter: per-channel word queues drive the requesters,
// a burst-framing reference model fills the expected DI queue.
module tb_ezusb_tx_arbiter;
  localparam int NCH  = 4;
  localparam int MAXB = 4;
  localparam int ITO  = 16;

  logic              ifclk = 1'b0;
  logic              reset = 1'b1;
  logic [NCH*16-1:0] req_data = '0;
  logic [NCH-1:0]    req_valid = '0;
  logic [NCH-1:0]    req_last = '0;
  logic [NCH-1:0]    req_ready;
  logic [15:0]       DI;
  logic              DI_valid;
  logic              DI_ready = 1'b0;
  logic              DI_enable;
  logic [2:0]        grant_ch;
  logic              busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int npop = 0;
  bit bp_mode = 1'b0;

  logic [16:0] src_q [NCH][$];
  logic [16:0] mq [NCH][$];
  logic [15:0] exp_q [$];
  int m_rr = NCH - 1;

  ezusb_tx_arbiter #(
    .NCH(NCH),
    .MAX_BURST(MAXB),
    .IDLE_TO(ITO)
  ) dut (
    .ifclk(ifclk),
    .reset(reset),
    .req_data(req_data),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_ready(req_ready),
    .DI(DI),
    .DI_valid(DI_valid),
    .DI_ready(DI_ready),
    .DI_enable(DI_enable),
    .grant_ch(grant_ch),
    .busy(busy)
  );

  always #5 ifclk = ~ifclk;
  always @(posedge ifclk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // requester sources: hold the head word until accepted
  always begin : src_drv
    logic [NCH-1:0] acc;
    @(negedge ifclk);
    acc = req_valid & req_ready;
    @(posedge ifclk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (acc[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
      req_valid[c] = src_q[c].size() > 0;
      req_data[16*c +: 16] = req_valid[c] ? src_q[c][0][15:0] : 16'h0;
      req_last[c] = req_valid[c] ? src_q[c][0][16] : 1'b0;
    end
    DI_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [15:0] prev_di = '0;
  bit prev_stall = 1'b0;

  always begin : mon
    logic [15:0] w;
    @(negedge ifclk);
    if (!reset) begin
      if (prev_stall) begin
        check("hold_valid", 32'(DI_valid), 32'd1);
        check("hold_data", 32'(DI), 32'(prev_di));
      end
      if (DI_valid && DI_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got %h want none", DI);
        end else begin
          w = exp_q.pop_front();
          check("di_word", 32'(DI), 32'(w));
        end
        npop++;
      end
      prev_stall = DI_valid && !DI_ready;
      prev_di = DI;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge ifclk);
    #2;
  endtask

  task automatic add_word(int c, logic [15:0] d, logic l);
    src_q[c].push_back({l, d});
    mq[c].push_back({l, d});
  endtask

  // reference: whole bursts from queued words, round-robin after last grant
  task automatic model_run();
    int pick;
    int n;
    bit found;
    logic [16:0] w;
    forever begin
      found = 1'b0;
      pick = 0;
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (m_rr + k) % NCH;
        if (!found && mq[c].size() > 0) begin
          found = 1'b1;
          pick = c;
        end
      end
      if (!found) break;
      exp_q.push_back({4'hA, 1'b0, 3'(pick), 8'h00});
      n = 0;
      do begin
        w = mq[pick].pop_front();
        exp_q.push_back(w[15:0]);
        n++;
      end while (!w[16] && n < MAXB && mq[pick].size() > 0);
      exp_q.push_back({4'h5, 12'(n)});
      m_rr = pick;
    end
  endtask

  function automatic bit srcs_busy();
    for (int c = 0; c < NCH; c++)
      if (src_q[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic flush();
    for (int c = 0; c < NCH; c++) begin
      src_q[c].delete();
      mq[c].delete();
    end
    exp_q.delete();
  endtask

  task automatic drain(string name, int budget);
    int k;
    k = 0;
    while ((exp_q.size() > 0 || srcs_busy()) && k < budget) begin
      tick();
      k++;
    end
    total++;
    if (k >= budget) begin
      bad++;
      $display("FAIL %s_timeout: got %0d left want 0", name, exp_q.size());
      flush();
    end
    tick(3);
  endtask

  initial begin
    int t0;
    int k;
    int n;
    int n0;
    tick(3);
    check("rst_di", 32'(DI), 32'h0);
    check("rst_di_valid", 32'(DI_valid), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_di_enable", 32'(DI_enable), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_grant", 32'(grant_ch), 32'(NCH - 1));
    reset = 1'b0;
    tick(2);

    // single channel
    add_word(2, 16'h1111, 1'b0);
    add_word(2, 16'h2222, 1'b0);
    add_word(2, 16'h3333, 1'b1);
    model_run();
    tick(3);
    check("single_busy", 32'(busy), 32'h1);
    check("single_enable", 32'(DI_enable), 32'h1);
    check("single_grant", 32'(grant_ch), 32'h2);
    drain("single", 200);
    check("single_grant_after", 32'(grant_ch), 32'h2);
    check("single_busy_after", 32'(busy), 32'h0);
    check("single_enable_after", 32'(DI_enable), 32'h0);

    // round robin, one-word packets
    for (int i = 0; i < 4; i++) begin
      add_word(0, 16'($urandom), 1'b1);
      add_word(3, 16'($urandom), 1'b1);
    end
    model_run();
    drain("rr", 400);

    // burst limit
    for (int i = 0; i < 10; i++) add_word(1, 16'h0100 + 16'(i), i == 9);
    model_run();
    drain("burst", 400);

    // backpressure, 100 words on ch0
    bp_mode = 1'b1;
    for (int i = 0; i < 100; i++)
      add_word(0, 16'($urandom), ($urandom_range(0, 7) == 0) || i == 99);
    model_run();
    drain("bp", 3000);

    // random multi-channel rounds
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < NCH; c++) begin
        n = $urandom_range(0, 15);
        for (int i = 0; i < n; i++)
          add_word(c, 16'($urandom), ($urandom_range(0, 5) == 0) || i == n - 1);
      end
      model_run();
      drain("multi", 3000);
    end
    bp_mode = 1'b0;
    tick(2);

    // idle timeout
    add_word(1, 16'hBEE1, 1'b0);
    add_word(1, 16'hBEE2, 1'b0);
    model_run();
    k = 0;
    while (exp_q.size() > 1 && k < 200) begin
      tick();
      k++;
    end
    t0 = cyc;
    while (exp_q.size() > 0 && k < 400) begin
      tick();
      k++;
    end
    check("idle_gap_ok", 32'((cyc - t0) >= 16 && (cyc - t0) <= 18), 32'h1);
    drain("idle", 200);
    add_word(1, 16'hC001, 1'b1);
    model_run();
    drain("idle_again", 200);

    // reset mid-burst
    for (int i = 0; i < 20; i++) add_word(3, 16'h3000 + 16'(i), i == 19);
    model_run();
    n0 = npop;
    k = 0;
    while (npop < n0 + 8 && k < 200) begin
      tick();
      k++;
    end
    check("pre_reset_busy", 32'(busy), 32'h1);
    @(posedge ifclk);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_di_valid", 32'(DI_valid), 32'h0);
    check("mid_rst_req_ready", 32'(req_ready), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_grant", 32'(grant_ch), 32'(NCH - 1));
    flush();
    m_rr = NCH - 1;
    tick(3);
    reset = 1'b0;
    tick(2);
    add_word(3, 16'hD003, 1'b1);
    add_word(0, 16'hD000, 1'b1);
    model_run();
    tick(3);
    check("post_rst_grant", 32'(grant_ch), 32'h0);
    drain("post_rst", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
